// File: rtl/program_loader.sv
// Loads a framed byte stream (sync, length, instructions, XOR checksum) into program memory.
// Write strobe one cycle after each accepted INS_HI; in_ready drops only once the image is loaded.
module program_loader #(
    parameter int instruction_width = 12,
    parameter int program_mem_depth = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [7:0]                           in_byte,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic                                 wr_en,
    output logic [$clog2(program_mem_depth)-1:0] wr_addr,
    output logic [instruction_width-1:0]         wr_data,
    output logic                                 cpu_rst,
    output logic                                 done,
    output logic                                 error
);

    localparam int          AW       = $clog2(program_mem_depth);
    localparam logic [7:0]  SYNC     = 8'hA5;
    localparam logic [16:0] DEPTH17  = 17'(program_mem_depth);
    // INS_HI bits that must be zero: everything above bit instruction_width-9
    localparam logic [7:0]  HI_MASK  = 8'hFF << (instruction_width - 8);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_INS_LO, S_INS_HI, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             chk_q, chk_d;
    logic [7:0]             lo_q, lo_d;
    logic [15:0]            len_q, len_d;
    logic [15:0]            idx_q, idx_d;
    logic                   in_ready_q;
    logic                   wr_en_q, wr_en_d;
    logic [AW-1:0]          wr_addr_q, wr_addr_d;
    logic [instruction_width-1:0] wr_data_q, wr_data_d;
    logic                   cpu_rst_q, done_q, error_q;
    logic                   accept;
    logic [15:0]            len_new;

    assign accept  = in_valid && in_ready_q;
    assign len_new = {in_byte, len_q[7:0]};

    always_comb begin
        state_d   = state_q;
        chk_d     = chk_q;
        lo_d      = lo_q;
        len_d     = len_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (in_byte == SYNC) begin
                        chk_d   = 8'h00;
                        state_d = S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    len_d[7:0] = in_byte;
                    chk_d      = chk_q ^ in_byte;
                    state_d    = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_d = len_new;
                    chk_d = chk_q ^ in_byte;
                    idx_d = 16'h0000;
                    if (len_new == 16'h0000 || {1'b0, len_new} > DEPTH17)
                        state_d = S_ERR;
                    else
                        state_d = S_INS_LO;
                end
                S_INS_LO: begin
                    lo_d    = in_byte;
                    chk_d   = chk_q ^ in_byte;
                    state_d = S_INS_HI;
                end
                S_INS_HI: begin
                    if ((in_byte & HI_MASK) != 8'h00) begin
                        state_d = S_ERR;
                    end else begin
                        chk_d     = chk_q ^ in_byte;
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx_q[AW-1:0];
                        wr_data_d = {in_byte[instruction_width-9:0], lo_q};
                        idx_d     = idx_q + 16'd1;
                        state_d   = (idx_q + 16'd1 == len_q) ? S_CHK : S_INS_LO;
                    end
                end
                S_CHK:   state_d = (in_byte == chk_q) ? S_DONE : S_ERR;
                S_DONE:  state_d = S_DONE;
                S_ERR: begin
                    if (in_byte == SYNC) begin
                        chk_d   = 8'h00;
                        state_d = S_LEN_LO;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Status outputs are registered from the next state so they track the FSM with no extra lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            chk_q      <= 8'h00;
            lo_q       <= 8'h00;
            len_q      <= 16'h0000;
            idx_q      <= 16'h0000;
            in_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            chk_q      <= chk_d;
            lo_q       <= lo_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            in_ready_q <= (state_d != S_DONE);
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_rst_q  <= (state_d != S_DONE);
            done_q     <= (state_d == S_DONE);
            error_q    <= (state_d == S_ERR);
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_rst  = cpu_rst_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: scoreboard of expected memory writes plus per-scenario status checks.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [11:0] wr_data;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [21:0] exp_q [$];
    logic [11:0] words [0:1023];
    logic        prev_wr = 1'b0;

    always #5 clk = ~clk;

    program_loader #(.instruction_width(12), .program_mem_depth(1024)) dut (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_rst(cpu_rst), .done(done), .error(error)
    );

    // Scoreboard: every write strobe must match the oldest expected {addr, data}.
    always @(negedge clk) begin
        logic [21:0] e;
        if (wr_en === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    n_fail++;
                    $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             wr_addr, wr_data, e[21:12], e[11:0]);
                end
            end
            n_checks++;
            if (prev_wr === 1'b1) begin
                n_fail++;
                $display("FAIL wr_en_width: got 2-cycle strobe, required 1 cycle");
            end
        end
        prev_wr = wr_en;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input int gaps);
        int t;
        repeat (gaps) begin @(negedge clk); in_valid = 1'b0; end
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        if (in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_frame(input int n, input int gapmax, input int ck_ovr);
        logic [7:0]  ck, lo, hi;
        logic [15:0] nn;
        nn = 16'(n);
        send_byte(8'hA5, int'($urandom_range(gapmax, 0)));
        send_byte(nn[7:0], int'($urandom_range(gapmax, 0)));
        send_byte(nn[15:8], int'($urandom_range(gapmax, 0)));
        ck = nn[7:0] ^ nn[15:8];
        for (int i = 0; i < n; i++) begin
            lo = words[i][7:0];
            hi = {4'h0, words[i][11:8]};
            send_byte(lo, int'($urandom_range(gapmax, 0)));
            send_byte(hi, int'($urandom_range(gapmax, 0)));
            exp_q.push_back({10'(i), words[i]});
            ck = ck ^ lo ^ hi;
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if (wr_en !== 1'b1) begin
                n_fail++;
                $display("FAIL wr_en_timing word %0d: got wr_en=%b, required 1", i, wr_en);
            end
        end
        send_byte((ck_ovr < 0) ? ck : 8'(ck_ovr), int'($urandom_range(gapmax, 0)));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_byte = 8'hA5;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, cpu_rst, done, error} !== {1'b1, 1'b0, 10'd0, 12'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b we=%b a=%0d d=%h crst=%b done=%b err=%b, required 1 0 0 000 1 0 0",
                     in_ready, wr_en, wr_addr, wr_data, cpu_rst, done, error);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, cpu_rst, done, error} !== {1'b1, 1'b0, 10'd0, 12'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL post_reset_values: got rdy=%b we=%b a=%0d d=%h crst=%b done=%b err=%b, required 1 0 0 000 1 0 0",
                     in_ready, wr_en, wr_addr, wr_data, cpu_rst, done, error);
        end
    endtask

    task automatic test_good_frame();
        do_reset();
        words[0] = 12'h134;
        words[1] = 12'hFFF;
        send_frame(2, 0, 8'hC7);
        n_checks++;
        if ({done, cpu_rst, in_ready, error} !== 4'b1000) begin
            n_fail++;
            $display("FAIL good_frame_status: got done=%b crst=%b rdy=%b err=%b, required 1 0 0 0", done, cpu_rst, in_ready, error);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL good_frame_writes: got %0d pending, required 0", exp_q.size());
        end
        // Bytes offered in DONE must be ignored.
        in_valid = 1'b1; in_byte = 8'hA5;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({done, cpu_rst, in_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL done_sticky: got done=%b crst=%b rdy=%b, required 1 0 0", done, cpu_rst, in_ready);
        end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        words[0] = 12'h134;
        words[1] = 12'hFFF;
        send_frame(2, 1, 8'h00);
        n_checks++;
        if ({error, cpu_rst, done, in_ready} !== 4'b1101) begin
            n_fail++;
            $display("FAIL bad_checksum_status: got err=%b crst=%b done=%b rdy=%b, required 1 1 0 1", error, cpu_rst, done, in_ready);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bad_checksum_writes: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_garbage_zero_len();
        do_reset();
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        @(negedge clk); in_valid = 1'b0;
        n_checks++;
        if ({error, cpu_rst} !== 2'b01) begin
            n_fail++;
            $display("FAIL garbage_idle: got err=%b crst=%b, required 0 1", error, cpu_rst);
        end
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk); in_valid = 1'b0;
        n_checks++;
        if (error !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_len_error: got err=%b, required 1", error);
        end
        send_byte(8'hA5, 0);
        @(negedge clk); in_valid = 1'b0;
        n_checks++;
        if ({error, cpu_rst} !== 2'b01) begin
            n_fail++;
            $display("FAIL sync_clears_error: got err=%b crst=%b, required 0 1", error, cpu_rst);
        end
    endtask

    task automatic test_len_too_big();
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        @(negedge clk); in_valid = 1'b0;
        n_checks++;
        if (error !== 1'b1) begin
            n_fail++;
            $display("FAIL len_too_big: got err=%b, required 1", error);
        end
    endtask

    task automatic test_bad_ins_hi();
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h34, 0);
        send_byte(8'h01, 0);
        exp_q.push_back({10'd0, 12'h134});
        send_byte(8'h55, 1);
        send_byte(8'h10, 0);
        @(negedge clk); in_valid = 1'b0;
        n_checks++;
        if ({error, wr_en} !== 2'b10) begin
            n_fail++;
            $display("FAIL bad_ins_hi: got err=%b we=%b, required 1 0", error, wr_en);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bad_ins_hi_writes: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_rst_mid_frame();
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h34, 0);
        // rst coincides with the INS_HI acceptance edge: the write must not happen.
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_byte = 8'h01;
        @(negedge clk);
        n_checks++;
        if ({wr_en, cpu_rst, in_ready, error, done} !== 5'b01100) begin
            n_fail++;
            $display("FAIL rst_mid_frame: got we=%b crst=%b rdy=%b err=%b done=%b, required 0 1 1 0 0",
                     wr_en, cpu_rst, in_ready, error, done);
        end
        rst = 1'b0; in_valid = 1'b0;
        // A stray INS_HI byte after reset must be discarded in IDLE.
        send_byte(8'h01, 0);
        @(negedge clk); in_valid = 1'b0;
        n_checks++;
        if ({wr_en, error, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_then_stray: got we=%b err=%b done=%b, required 0 0 0", wr_en, error, done);
        end
        for (int i = 0; i < 3; i++) words[i] = 12'($urandom);
        send_frame(3, 1, -1);
        n_checks++;
        if ({done, cpu_rst, exp_q.size() == 0} !== 3'b101) begin
            n_fail++;
            $display("FAIL reload_after_rst: got done=%b crst=%b pending=%0d, required 1 0 0", done, cpu_rst, exp_q.size());
        end
    endtask

    task automatic test_full_depth();
        do_reset();
        for (int i = 0; i < 1024; i++) words[i] = 12'($urandom);
        send_frame(1024, 2, -1);
        n_checks++;
        if ({done, cpu_rst, in_ready, error} !== 4'b1000) begin
            n_fail++;
            $display("FAIL full_depth_status: got done=%b crst=%b rdy=%b err=%b, required 1 0 0 0", done, cpu_rst, in_ready, error);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_depth_writes: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_garbage_zero_len();
        test_len_too_big();
        test_bad_ins_hi();
        test_rst_mid_frame();
        test_full_depth();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter instruction_width, default 12, meaning program word width; legal range 9..16.
REQ-002 SHALL have parameter program_mem_depth, default 1024, meaning number of program memory words.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_byte  input  8  incoming load-stream byte.
REQ-006 SHALL have port in_valid  input  1  in_byte valid; a byte is accepted on a cycle with in_valid && in_ready.
REQ-007 SHALL have port in_ready  output  1  loader can accept a byte this cycle.
REQ-008 SHALL have port wr_en  output  1  one-cycle program memory write strobe.
REQ-009 SHALL have port wr_addr  output  $clog2(program_mem_depth)  write address.
REQ-010 SHALL have port wr_data  output  instruction_width  write data.
REQ-011 SHALL have port cpu_rst  output  1  active-high reset to the fetch/ALU core; held until load completes.
REQ-012 SHALL have port done  output  1  image loaded and checksum good; sticky.
REQ-013 SHALL have port error  output  1  frame rejected; sticky until the next sync byte or rst.

Function
REQ-014 SHALL accept frames as: sync 0xA5, LEN_LO, LEN_HI (N = 16-bit little-endian instruction count), N x {INS_LO = instr[7:0], INS_HI = instr[instruction_width-1:8] in the low bits}, CHK.
REQ-015 SHALL implement states IDLE, LEN_LO, LEN_HI, INS_LO, INS_HI, CHK, DONE, ERR, advancing one state per accepted byte.
REQ-016 SHALL stay in IDLE, discarding bytes, until 0xA5 is accepted, then go to LEN_LO.
REQ-017 SHALL go to ERR after LEN_HI is accepted if N == 0 or N > program_mem_depth; otherwise go to INS_LO with index = 0.
REQ-018 SHALL go to ERR, with no write, if INS_HI has any bit set above bit (instruction_width-9).
REQ-019 SHALL, on a valid INS_HI acceptance, assert wr_en on the following cycle for exactly one cycle, with wr_addr = index and wr_data = {INS_HI bits, INS_LO}, then increment index.
REQ-020 SHALL go to CHK after the Nth INS_HI; otherwise return to INS_LO.
REQ-021 SHALL compute the checksum as the 8-bit XOR of all accepted bytes after sync (LEN_LO through the last INS_HI); CHK equal to it -> DONE, otherwise ERR.
REQ-022 SHALL hold in_ready = 1 in every state except DONE, where in_ready = 0.
REQ-023 SHALL, in DONE, hold done = 1, cpu_rst = 0 and wr_en = 0 until rst; done and cpu_rst change in the same cycle.
REQ-024 SHALL, in ERR, hold error = 1 and cpu_rst = 1, discard bytes other than 0xA5, and on 0xA5 clear error, clear the checksum and go to LEN_LO.
REQ-025 SHALL hold cpu_rst = 1 in every state other than DONE.
REQ-026 SHALL treat an idle cycle (in_valid = 0) mid-frame as a stall with no state change; there is no timeout.
REQ-027 SHALL leave previously written words in memory on error; a later good frame overwrites from address 0.

Reset
REQ-028 SHALL, while rst = 1 (any state, including mid-frame), enter IDLE with index = 0 and checksum = 0.
REQ-029 SHALL drive these values while rst = 1 and in the cycle after: in_ready = 1, wr_en = 0, wr_addr = 0, wr_data = 0, cpu_rst = 1, done = 0, error = 0.
REQ-030 SHALL not issue a pending wr_en when rst is asserted in the cycle it would occur.

Verification
REQ-031 Good frame A5 02 00 34 01 FF 0F CK (CK = 0x02^0x00^0x34^0x01^0xFF^0x0F = 0xC7) -> writes 0x134 @0 and 0xFFF @1, then done = 1, cpu_rst = 0, in_ready = 0.
REQ-032 Same frame with CK = 0x00 -> both writes occur, then error = 1, cpu_rst = 1, done = 0.
REQ-033 Bytes 11 22 A5 then LEN = 0x0000 -> leading bytes ignored, no writes, error = 1 after LEN_HI; a following A5 clears error.
REQ-034 LEN = 0x0401 with depth 1024 -> error after LEN_HI; INS_HI = 0x10 in a valid frame -> error, no write for that word.
REQ-035 Random in_valid gaps across a 1024-word frame -> addresses 0..1023 written once each, in order, data matching the stream.
REQ-036 rst pulsed between INS_LO and INS_HI -> no wr_en, IDLE, cpu_rst = 1; a subsequent good frame loads from address 0.
